// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the PC.
// It issues word reads over a req/ack handshake and presents one instruction
// to decode over a valid/ready handshake. Jump redirects from execute discard
// any in-flight or held instruction.
// Optional build macro FETCH_PERF_EN adds two saturating performance
// counters, perf_fetched and perf_bubbles.
module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_bubbles
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] pending;
  logic              in_req, in_hold, in_drain, in_idle;
  logic              take;     // downstream consumes the held instruction
  logic              capture;  // memory data accepted into the hold register

  assign in_idle  = (state == S_IDLE);
  assign in_req   = (state == S_REQ);
  assign in_hold  = (state == S_HOLD);
  assign in_drain = (state == S_DRAIN);

  assign take    = in_hold && inst_ready && !redirect;
  assign capture = in_req && imem_ack && !redirect;

  assign imem_req   = in_req || in_drain;
  assign imem_addr  = fetch_addr;
  assign inst_valid = in_hold;

  // Next-state decode; a redirect never cancels a request the memory has
  // not yet acked, it parks in DRAIN until the old read completes.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (run) state_nx = S_REQ;
      S_REQ: begin
        if (imem_ack && !redirect)      state_nx = S_HOLD;
        else if (!imem_ack && redirect) state_nx = S_DRAIN;
      end
      S_HOLD:  if (redirect || inst_ready) state_nx = run ? S_REQ : S_IDLE;
      S_DRAIN: if (imem_ack) state_nx = S_REQ;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Fetch address and pending redirect target. imem_addr must stay put while
  // a request is outstanding, so REQ-without-ack redirects go to pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= RESET_PC;
      pending    <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: if (redirect) fetch_addr <= redirect_pc;
        S_REQ: begin
          if (imem_ack && redirect)       fetch_addr <= redirect_pc;
          else if (imem_ack)              fetch_addr <= fetch_addr + PC_ONE;
          else if (redirect)              pending    <= redirect_pc;
        end
        S_HOLD: if (redirect) fetch_addr <= redirect_pc;
        S_DRAIN: begin
          if (imem_ack)      fetch_addr <= redirect ? redirect_pc : pending;
          else if (redirect) pending    <= redirect_pc;
        end
        default: ;
      endcase
    end
  end

  // Instruction hold register; only loaded on an un-redirected ack in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (capture) begin
      inst    <= imem_rdata;
      inst_pc <= fetch_addr;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: completed handshakes and request cycles with no ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (take && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (imem_req && !imem_ack && perf_bubbles != 16'hFFFF)
        perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

  // in_idle exists for readability of the decode; tie it off for lint.
  logic unused_ok;
  assign unused_ok = in_idle;

endmodule
